// File: rtl/par_ser_gen_chk_if.sv
// Signal bundle for the parity serialiser/checker: parallel word handshake,
// outgoing serial frame, incoming serial frame and checker status.
interface par_ser_gen_chk_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             odd;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             par_out;
  logic             chk_in;
  logic             chk_valid;
  logic             chk_last;
  logic             chk_err;
  logic [CNT_W-1:0] err_cnt;

  // Environment side: offers words, feeds the checker, observes results
  modport master (
    output in_valid, in_data, odd, chk_in, chk_valid, chk_last,
    input  in_ready, ser_out, ser_valid, ser_last, par_out, chk_err, err_cnt
  );

  modport slave (
    input  in_valid, in_data, odd, chk_in, chk_valid, chk_last,
    output in_ready, ser_out, ser_valid, ser_last, par_out, chk_err, err_cnt
  );
endinterface

// File: rtl/par_ser_gen_chk.sv
// Parity frame generator (word -> LSB-first serial + parity bit) and an
// independent serial frame checker with a saturating error counter.
module par_ser_gen_chk #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  par_ser_gen_chk_if.slave bus
);
  localparam int BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int CHK_W = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] sr;
  logic [BIT_W-1:0] bit_cnt;
  logic             acc;
  logic             odd_q;
  logic             accept;
  logic             last_bit;

  logic             in_ready_q, in_ready_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             par_out_q;

  logic [CHK_W-1:0] chk_cnt;
  logic             chk_acc;
  logic             chk_err_q;
  logic             frame_err;
  logic [CNT_W-1:0] err_cnt_q;

  assign accept   = bus.in_valid & in_ready_q;
  assign last_bit = (bit_cnt == BIT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SHIFT;
      SHIFT:   if (last_bit) next_state = PAR;
      PAR:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered, so this computes what the link shows next cycle:
  // bit 0 appears right after the accept edge and parity after the last bit.
  always_comb begin
    in_ready_d  = 1'b0;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    ser_last_d  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ser_out_d   = bus.in_data[0];
          ser_valid_d = 1'b1;
        end else begin
          in_ready_d  = 1'b1;
        end
      end
      SHIFT: begin
        ser_valid_d = 1'b1;
        if (last_bit) begin
          ser_out_d  = acc ^ odd_q;
          ser_last_d = 1'b1;
        end else begin
          ser_out_d  = sr[0];
        end
      end
      PAR:     in_ready_d = 1'b1;
      default: in_ready_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      in_ready_q  <= in_ready_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  // sr holds the bits not yet driven; acc already includes the driven ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      bit_cnt   <= '0;
      acc       <= 1'b0;
      odd_q     <= 1'b0;
      par_out_q <= 1'b0;
    end else if (state == IDLE && accept) begin
      sr        <= bus.in_data >> 1;
      bit_cnt   <= '0;
      acc       <= bus.in_data[0];
      odd_q     <= bus.odd;
      par_out_q <= (^bus.in_data) ^ bus.odd;
    end else if (state == SHIFT && !last_bit) begin
      sr      <= sr >> 1;
      bit_cnt <= bit_cnt + BIT_W'(1);
      acc     <= acc ^ sr[0];
    end
  end

  assign frame_err = ((chk_acc ^ bus.chk_in) != bus.odd) || (chk_cnt != CHK_W'(WIDTH));

  // Count stops at WIDTH+1 so an over-long frame cannot wrap back to WIDTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt   <= '0;
      chk_acc   <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= 1'b0;
      if (bus.chk_valid) begin
        if (bus.chk_last) begin
          chk_err_q <= frame_err;
          chk_acc   <= 1'b0;
          chk_cnt   <= '0;
        end else begin
          chk_acc <= chk_acc ^ bus.chk_in;
          if (chk_cnt != CHK_W'(WIDTH + 1)) chk_cnt <= chk_cnt + CHK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    err_cnt_q <= '0;
    else if (chk_err_q && err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + CNT_W'(1);
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.par_out   = par_out_q;
  assign bus.chk_err   = chk_err_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule
